// File: rtl/j1_io_pkg.sv
// Shared definitions for the j1 IO responder: register addresses, STATUS bit
// positions and the state encoding used by both UART FSMs.
package j1_io_pkg;

  localparam logic [15:0] IO_LEDS   = 16'h0004;
  localparam logic [15:0] IO_DATA   = 16'h1000;
  localparam logic [15:0] IO_STATUS = 16'h2000;
  localparam logic [15:0] IO_TICKS  = 16'h4000;

  localparam int ST_TX_READY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_OVERRUN  = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/j1_io_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and divider.
// Emits the received byte with a one-cycle done pulse; framing errors are dropped.
module j1_io_uart_rx
  import j1_io_pkg::*;
#(
  parameter int DIVISOR = 417
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_done
);
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);

  logic          sync1_r, sync2_r, prev_r;
  logic          fall_s, bit_end_s;
  uart_state_t   state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r, byte_r;
  logic          done_r;

  assign fall_s    = prev_r && !sync2_r;
  assign bit_end_s = (cnt_r == {CW{1'b0}});
  assign rx_byte   = byte_r;
  assign rx_done   = done_r;

  // Bring the asynchronous line into clk and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= uart_rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Receive FSM; after a bad stop bit it needs a fresh falling edge, so it waits for the line to rise.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      byte_r  <= 8'h00;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_r <= START;
            cnt_r   <= HALF_LAST;
          end
        end
        START: begin
          if (!bit_end_s) begin
            cnt_r <= cnt_r - 1'b1;
          end else if (sync2_r) begin
            state_r <= IDLE;
            cnt_r   <= BIT_LAST;
          end else begin
            state_r <= DATA;
            cnt_r   <= BIT_LAST;
            bit_r   <= 3'd0;
          end
        end
        DATA: begin
          if (!bit_end_s) begin
            cnt_r <= cnt_r - 1'b1;
          end else begin
            shift_r <= {sync2_r, shift_r[7:1]};
            cnt_r   <= BIT_LAST;
            if (bit_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_r <= bit_r + 3'd1;
            end
          end
        end
        STOP: begin
          if (!bit_end_s) begin
            cnt_r <= cnt_r - 1'b1;
          end else begin
            state_r <= IDLE;
            cnt_r   <= BIT_LAST;
            if (sync2_r) begin
              byte_r <= shift_r;
              done_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= BIT_LAST;
        end
      endcase
    end
  end

endmodule

// File: rtl/j1_io_uart.sv
// j1 IO responder: register map, TX FIFO with 8N1 transmitter, RX holding register, LEDs.
// Define J1_IO_TICKS_EN to add a free-running cycle counter at IO_TICKS.
module j1_io_uart
  import j1_io_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIVISOR  = 417,
  parameter int TX_DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      io_addr,
  input  logic [WIDTH-1:0] io_dout,
  output logic [WIDTH-1:0] io_din,
  output logic             uart_tx,
  input  logic             uart_rx,
  output logic [7:0]       leds
);
  localparam int CW = $clog2(DIVISOR);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST   = CW'(DIVISOR - 1);
  localparam logic [AW:0]   FIFO_COUNT = (AW + 1)'(TX_DEPTH);

  logic [7:0]    fifo_mem_r [TX_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          tx_full_s, tx_empty_s, push_s, pop_s, tx_bit_end_s;
  logic          leds_wr_s, data_wr_s, data_rd_s, status_wr_s;
  uart_state_t   tx_state_r;
  logic [CW-1:0] tx_cnt_r;
  logic [2:0]    tx_bit_r;
  logic [7:0]    tx_shift_r;
  logic          uart_tx_r;
  logic [7:0]    leds_r;
  logic          rx_valid_r, overrun_r;
  logic [7:0]    rx_byte_s;
  logic          rx_done_s;
  logic [2:0]    status_s;
  logic          unused_s;

  assign unused_s     = &{1'b0, io_dout[WIDTH-1:8]};
  assign leds_wr_s    = io_wr && (io_addr == IO_LEDS);
  assign data_wr_s    = io_wr && (io_addr == IO_DATA);
  assign data_rd_s    = io_rd && (io_addr == IO_DATA);
  assign status_wr_s  = io_wr && (io_addr == IO_STATUS);
  assign tx_full_s    = (count_r == FIFO_COUNT);
  assign tx_empty_s   = (count_r == {(AW + 1){1'b0}});
  assign tx_bit_end_s = (tx_cnt_r == {CW{1'b0}});
  // A full FIFO refuses the push even if the transmitter pops in the same cycle.
  assign push_s       = data_wr_s && !tx_full_s;
  assign pop_s        = !tx_empty_s &&
                        ((tx_state_r == IDLE) || ((tx_state_r == STOP) && tx_bit_end_s));
  assign uart_tx      = uart_tx_r;
  assign leds         = leds_r;

  j1_io_uart_rx #(.DIVISOR(DIVISOR)) u_rx (
    .clk     (clk),
    .resetq  (resetq),
    .uart_rx (uart_rx),
    .rx_byte (rx_byte_s),
    .rx_done (rx_done_s)
  );

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= io_dout[7:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r <= count_r + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
    end
  end

  // Transmit FSM; back-to-back bytes chain from STOP straight into START.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_r <= IDLE;
      tx_cnt_r   <= {CW{1'b0}};
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      uart_tx_r  <= 1'b1;
    end else begin
      case (tx_state_r)
        IDLE: begin
          if (pop_s) begin
            tx_state_r <= START;
            tx_cnt_r   <= BIT_LAST;
            tx_shift_r <= fifo_mem_r[rd_ptr_r];
            uart_tx_r  <= 1'b0;
          end
        end
        START: begin
          if (!tx_bit_end_s) begin
            tx_cnt_r <= tx_cnt_r - 1'b1;
          end else begin
            tx_state_r <= DATA;
            tx_cnt_r   <= BIT_LAST;
            tx_bit_r   <= 3'd0;
            uart_tx_r  <= tx_shift_r[0];
          end
        end
        DATA: begin
          if (!tx_bit_end_s) begin
            tx_cnt_r <= tx_cnt_r - 1'b1;
          end else begin
            tx_cnt_r <= BIT_LAST;
            if (tx_bit_r == 3'd7) begin
              tx_state_r <= STOP;
              uart_tx_r  <= 1'b1;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              uart_tx_r  <= tx_shift_r[1];
            end
          end
        end
        STOP: begin
          if (!tx_bit_end_s) begin
            tx_cnt_r <= tx_cnt_r - 1'b1;
          end else if (pop_s) begin
            tx_state_r <= START;
            tx_cnt_r   <= BIT_LAST;
            tx_shift_r <= fifo_mem_r[rd_ptr_r];
            uart_tx_r  <= 1'b0;
          end else begin
            tx_state_r <= IDLE;
            tx_cnt_r   <= BIT_LAST;
          end
        end
        default: begin
          tx_state_r <= IDLE;
          uart_tx_r  <= 1'b1;
        end
      endcase
    end
  end

  // LEDs and RX flags; a completing byte beats a simultaneous read or STATUS write.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      leds_r     <= 8'h00;
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (leds_wr_s) leds_r <= io_dout[7:0];
      if (rx_done_s) begin
        rx_valid_r <= 1'b1;
      end else if (data_rd_s) begin
        rx_valid_r <= 1'b0;
      end
      if (rx_done_s && rx_valid_r && !data_rd_s) begin
        overrun_r <= 1'b1;
      end else if (status_wr_s) begin
        overrun_r <= 1'b0;
      end
    end
  end

`ifdef J1_IO_TICKS_EN
  logic [WIDTH-1:0] ticks_r;

  // Free-running cycle counter, cleared by any write to its address.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      ticks_r <= {WIDTH{1'b0}};
    end else if (io_wr && (io_addr == IO_TICKS)) begin
      ticks_r <= {WIDTH{1'b0}};
    end else begin
      ticks_r <= ticks_r + 1'b1;
    end
  end
`endif

  // Read mux; the core latches io_din at the same edge as the strobe.
  always_comb begin
    status_s              = 3'b000;
    status_s[ST_TX_READY] = !tx_full_s;
    status_s[ST_RX_VALID] = rx_valid_r;
    status_s[ST_OVERRUN]  = overrun_r;
    io_din                = {WIDTH{1'b0}};
    case (io_addr)
      IO_LEDS:   io_din = {{(WIDTH - 8){1'b0}}, leds_r};
      IO_DATA:   io_din = {{(WIDTH - 8){1'b0}}, rx_byte_s};
      IO_STATUS: io_din = {{(WIDTH - 3){1'b0}}, status_s};
`ifdef J1_IO_TICKS_EN
      IO_TICKS:  io_din = ticks_r;
`endif
      default:   io_din = {WIDTH{1'b0}};
    endcase
  end

endmodule
